// File: rtl/spike_depacketizer_if.sv
// -----------------------------------------------------------------------------
// spike_depacketizer_if
//   Handshake bundle between the NoC, the spike depacketizer and the neuron
//   consumer.
//
//   Input side  : in_valid, in_ready, in_packet[WIDTH_PACKET-1:0]
//   Output side : out_valid, out_ready, out_idx[1:0], out_mem[WIDTH-1:0],
//                 out_spike, out_src[2:0], out_last
//
//   Modports:
//     slave  - the depacketizer (consumes packets, produces neuron beats)
//     master - the environment (drives packets, accepts neuron beats)
// -----------------------------------------------------------------------------
interface spike_depacketizer_if #(
  parameter int WIDTH_PACKET = 35,
  parameter int WIDTH        = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_PACKET-1:0] in_packet;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_idx;
  logic [WIDTH-1:0]        out_mem;
  logic                    out_spike;
  logic [2:0]              out_src;
  logic                    out_last;

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_idx, out_mem, out_spike, out_src, out_last
  );

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_idx, out_mem, out_spike, out_src, out_last
  );
endinterface

// File: rtl/spike_depacketizer.sv
// -----------------------------------------------------------------------------
// spike_depacketizer
//   Accepts one NoC packet carrying three neurons (membrane + spike bit each),
//   filters it on destination address, and replays the neurons as three
//   ready/valid beats (index 0, 1, 2). Packets for other addresses are dropped
//   and counted.
//
//   Packet layout: dest[34:32] src[31:29] unused[28:27] (bits 26:24 spike[2:0])
//                  membrane[i] at [8i+7:8i]
//
//   Ports:
//     clk        - rising-edge clock
//     rst_n      - asynchronous active-low reset
//     bus        - spike_depacketizer_if.slave (packet in, neuron beats out)
//     drop_cnt   - discarded-packet count, saturates at 255
//     spike_cnt  - per-neuron spike counts, neuron i at [8i+7:8i]
//
//   Optional feature: define SPIKE_CNT_EN to build the saturating per-neuron
//   spike counters; otherwise spike_cnt is tied to zero.
// -----------------------------------------------------------------------------
module spike_depacketizer #(
  parameter int         WIDTH_PACKET = 35,
  parameter int         WIDTH        = 8,
  parameter logic [2:0] OWN_ADDR     = 3'b100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spike_depacketizer_if.slave     bus,
  output logic [7:0]              drop_cnt,
  output logic [23:0]             spike_cnt
);

  localparam int SPIKE_LSB = 3 * WIDTH;
  localparam int SRC_MSB   = WIDTH_PACKET - 4;
  localparam int DEST_MSB  = WIDTH_PACKET - 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              r_state;
  logic [1:0]          r_beat;
  logic [3*WIDTH-1:0]  r_membrane;
  logic [2:0]          r_spikes;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [1:0]          r_out_idx;
  logic [WIDTH-1:0]    r_out_mem;
  logic                r_out_spike;
  logic [2:0]          r_out_src;
  logic                r_out_last;
  logic [7:0]          r_drop_cnt;

  // Packet field views.
  logic [2:0]          w_dest;
  logic [2:0]          w_src;
  logic [2:0]          w_spikes;
  logic [3*WIDTH-1:0]  w_membrane;
  logic [1:0]          w_unused_bits;
  logic [1:0]          w_next_beat;
  logic [WIDTH-1:0]    w_next_mem;

  assign w_dest        = bus.in_packet[DEST_MSB -: 3];
  assign w_src         = bus.in_packet[SRC_MSB -: 3];
  assign w_spikes      = bus.in_packet[SPIKE_LSB +: 3];
  assign w_membrane    = bus.in_packet[SPIKE_LSB-1:0];
  assign w_unused_bits = bus.in_packet[SRC_MSB-3 -: 2];
  assign w_next_beat   = r_beat + 2'd1;

  // Membrane for the beat that follows the current one (only beats 1 and 2
  // are ever reached this way; beat 0 is loaded straight from the packet).
  always_comb begin
    // NOTE: a default assignment up front keeps every path covered, so no
    // latch is inferred even if the case list is later edited.
    w_next_mem = r_membrane[WIDTH-1:0];
    case (w_next_beat)
      2'd1:    w_next_mem = r_membrane[WIDTH +: WIDTH];
      2'd2:    w_next_mem = r_membrane[2*WIDTH +: WIDTH];
      default: w_next_mem = r_membrane[WIDTH-1:0];
    endcase
  end

  // Single-process FSM; every output is a register updated on the edge that
  // changes state, so the first beat appears the cycle after acceptance and
  // nothing combinational links in_valid to out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= 2'd0;
      r_membrane  <= '0;
      r_spikes    <= 3'b000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_idx   <= 2'd0;
      r_out_mem   <= '0;
      r_out_spike <= 1'b0;
      r_out_src   <= 3'b000;
      r_out_last  <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            if (w_dest == OWN_ADDR) begin
              // NOTE: non-blocking assignments here so every register sees
              // the pre-edge values, independent of statement order.
              r_state     <= EMIT;
              r_beat      <= 2'd0;
              r_membrane  <= w_membrane;
              r_spikes    <= w_spikes;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_idx   <= 2'd0;
              r_out_mem   <= w_membrane[WIDTH-1:0];
              r_out_spike <= w_spikes[0];
              r_out_src   <= w_src;
              r_out_last  <= 1'b0;
            end else if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt  <= r_drop_cnt + 8'd1;
            end
          end
        end
        EMIT: begin
          // Without out_ready nothing is written, so the beat holds stable.
          if (bus.out_ready) begin
            if (r_beat == 2'd2) begin
              r_state     <= IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_beat      <= w_next_beat;
              r_out_idx   <= w_next_beat;
              r_out_mem   <= w_next_mem;
              r_out_spike <= r_spikes[w_next_beat];
              r_out_last  <= (w_next_beat == 2'd2);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_mem   = r_out_mem;
  assign bus.out_spike = r_out_spike;
  assign bus.out_src   = r_out_src;
  assign bus.out_last  = r_out_last;
  assign drop_cnt      = r_drop_cnt;

`ifdef SPIKE_CNT_EN
  logic [7:0] r_spike_cnt [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_spike_cnt[i] <= 8'd0;
    end else if (r_out_valid && bus.out_ready && r_out_spike) begin
      for (int i = 0; i < 3; i++) begin
        if (r_out_idx == 2'(i) && r_spike_cnt[i] != 8'hFF)
          r_spike_cnt[i] <= r_spike_cnt[i] + 8'd1;
      end
    end
  end

  assign spike_cnt = {r_spike_cnt[2], r_spike_cnt[1], r_spike_cnt[0]};
`else
  assign spike_cnt = 24'd0;
`endif

endmodule

// File: tb/tb_spike_depacketizer.sv
// -----------------------------------------------------------------------------
// tb_spike_depacketizer
//   Directed self-checking bench for spike_depacketizer. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_spike_depacketizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  drop_cnt;
  logic [23:0] spike_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  spike_depacketizer_if #(.WIDTH_PACKET(35), .WIDTH(8)) bus ();

  spike_depacketizer #(
    .WIDTH_PACKET (35),
    .WIDTH        (8),
    .OWN_ADDR     (3'b100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .drop_cnt  (drop_cnt),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

`ifdef SPIKE_CNT_EN
  localparam logic [23:0] EXP_CNT_ONE = 24'h010001;
  localparam logic [23:0] EXP_CNT_SAT = 24'hFFFFFF;
`else
  localparam logic [23:0] EXP_CNT_ONE = 24'h000000;
  localparam logic [23:0] EXP_CNT_SAT = 24'h000000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] pkt(input logic [2:0] d, input logic [2:0] s,
                                      input logic [1:0] u, input logic [2:0] sp,
                                      input logic [23:0] m);
    return {d, s, u, sp, m};
  endfunction

  task automatic check_beat(input string tag, input logic [1:0] idx, input logic [7:0] mem,
                            input logic spk, input logic [2:0] src, input logic last);
    check({tag, ".valid"}, bus.out_valid, 1'b1);
    check({tag, ".idx"},   bus.out_idx,   idx);
    check({tag, ".mem"},   bus.out_mem,   mem);
    check({tag, ".spike"}, bus.out_spike, spk);
    check({tag, ".src"},   bus.out_src,   src);
    check({tag, ".last"},  bus.out_last,  last);
  endtask

  // Offer one packet, then drain its beats with out_ready high; bounded wait.
  task automatic run_packet(input logic [34:0] p);
    bit done = 0;
    bus.in_valid  = 1'b1;
    bus.in_packet = p;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (bus.out_valid && bus.out_last) done = 1;
      tick();
    end
    check("run_packet_done", done, 1'b1);
  endtask

  initial begin
    bit       held_ok;
    bit       no_valid;
    logic [34:0] p_main;

    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    p_main = pkt(3'b100, 3'b000, 2'b00, 3'b101, 24'h302010);

    // Reset state.
    #12;
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.drop_cnt",  drop_cnt,      8'd0);
    check("rst.spike_cnt", spike_cnt,     24'd0);
    check("rst.out_mem",   bus.out_mem,   8'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst.in_ready", bus.in_ready, 1'b1);

    // Reference packet, consumer always ready: beats on N+1..N+3, idle at N+4.
    bus.in_valid  = 1'b1;
    bus.in_packet = p_main;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("b0.in_ready", bus.in_ready, 1'b0);
    check_beat("b0", 2'd0, 8'h10, 1'b1, 3'b000, 1'b0);
    tick();
    check_beat("b1", 2'd1, 8'h20, 1'b0, 3'b000, 1'b0);
    tick();
    check_beat("b2", 2'd2, 8'h30, 1'b1, 3'b000, 1'b1);
    tick();
    check("n4.in_ready",  bus.in_ready,  1'b1);
    check("n4.out_valid", bus.out_valid, 1'b0);

    // Foreign destination: dropped, counted, then saturation after 300.
    bus.in_valid  = 1'b1;
    bus.in_packet = pkt(3'b010, 3'b001, 2'b00, 3'b111, 24'hABCDEF);
    tick();
    check("drop1.out_valid", bus.out_valid, 1'b0);
    check("drop1.drop_cnt",  drop_cnt,      8'd1);
    check("drop1.in_ready",  bus.in_ready,  1'b1);
    no_valid = 1;
    for (int i = 0; i < 299; i++) begin
      tick();
      if (bus.out_valid) no_valid = 0;
    end
    bus.in_valid = 1'b0;
    check("drop300.no_valid", no_valid, 1'b1);
    check("drop300.drop_cnt", drop_cnt, 8'd255);

    // Stall during beat 1; unused bits set, non-zero src, in_valid held high.
    bus.in_valid  = 1'b1;
    bus.in_packet = pkt(3'b100, 3'b011, 2'b11, 3'b101, 24'h302010);
    bus.out_ready = 1'b1;
    tick();
    check_beat("st.b0", 2'd0, 8'h10, 1'b1, 3'b011, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    held_ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(bus.out_valid && bus.out_idx == 2'd1 && bus.out_mem == 8'h20 &&
            !bus.out_spike && bus.out_src == 3'b011 && !bus.out_last && !bus.in_ready))
        held_ok = 0;
    end
    check("stall.held", held_ok, 1'b1);
    check_beat("st.b1", 2'd1, 8'h20, 1'b0, 3'b011, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_beat("st.b2", 2'd2, 8'h30, 1'b1, 3'b011, 1'b1);
    tick();
    tick();
    check("st.no_extra", bus.out_valid, 1'b0);
    check("st.drop_cnt", drop_cnt, 8'd255);

    // Reset pulsed during beat 1 clears everything immediately.
    bus.in_valid  = 1'b1;
    bus.in_packet = p_main;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("pre_rst.idx", bus.out_idx, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", bus.out_valid, 1'b0);
    check("mrst.out_idx",   bus.out_idx,   2'd0);
    check("mrst.out_mem",   bus.out_mem,   8'd0);
    check("mrst.out_spike", bus.out_spike, 1'b0);
    check("mrst.out_src",   bus.out_src,   3'd0);
    check("mrst.out_last",  bus.out_last,  1'b0);
    check("mrst.drop_cnt",  drop_cnt,      8'd0);
    check("mrst.spike_cnt", spike_cnt,     24'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("mrst.in_ready", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_packet = p_main;
    tick();
    bus.in_valid = 1'b0;
    check_beat("rs.b0", 2'd0, 8'h10, 1'b1, 3'b000, 1'b0);
    tick();
    tick();
    tick();
    check("rs.spike_cnt", spike_cnt, EXP_CNT_ONE);

    // Spike counter saturation.
    for (int i = 0; i < 260; i++)
      run_packet(pkt(3'b100, 3'b010, 2'b00, 3'b111, 24'h050403));
    check("sat.spike_cnt", spike_cnt, EXP_CNT_SAT);
    check("sat.drop_cnt",  drop_cnt,  8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_depacketizer.md
SPIKE_DEPACKETIZER -- requirements
Module: spike_depacketizer

Interface
REQ-001 Parameter WIDTH_PACKET, default 35, SHALL be the NoC packet width.
REQ-002 Parameter WIDTH, default 8, SHALL be the membrane value width.
REQ-003 Parameter OWN_ADDR, default 3'b100, SHALL be the destination address this block accepts.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that in_packet carries a packet from the NoC.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a packet this cycle.
REQ-008 Port in_packet, input, WIDTH_PACKET bits, SHALL carry the fields dest[34:32], src[31:29], unused[28:27], spike[24+i] and membrane[8i+7:8i] for i=0..2.
REQ-009 Port out_valid, output, 1 bit, SHALL indicate a valid neuron beat.
REQ-010 Port out_ready, input, 1 bit, SHALL be the consumer's acceptance of a beat.
REQ-011 Ports out_idx (2 bits), out_mem (WIDTH bits), out_spike (1 bit), out_src (3 bits) and out_last (1 bit), all outputs, SHALL carry the neuron index, membrane, spike, source address and final-beat flag.
REQ-012 Port drop_cnt, output, 8 bits, SHALL count discarded packets and saturate at 255.
REQ-013 Port spike_cnt, output, 24 bits, SHALL hold per-neuron spike counts, with neuron i at [8i+7:8i].

Function
REQ-014 The FSM SHALL have two states: IDLE and EMIT.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In EMIT, in_ready SHALL be 0.
REQ-017 A handshake (in_valid && in_ready) with dest==OWN_ADDR SHALL register the packet, clear the beat counter to 0, and enter EMIT on the next cycle.
REQ-018 A handshake with dest!=OWN_ADDR SHALL discard the packet, increment drop_cnt (saturating), and remain in IDLE.
REQ-019 In EMIT, out_valid SHALL be 1, and the outputs SHALL be as follows: out_idx = beat, out_mem = membrane[beat], out_spike = spike[beat], out_src = registered src, out_last = (beat==2).
REQ-020 The first beat SHALL be presented exactly one cycle after the accepting edge.
REQ-021 On out_valid && out_ready with beat<2, the beat counter SHALL increment.
REQ-022 On out_valid && out_ready with beat==2, the block SHALL return to IDLE.
REQ-023 While out_valid && !out_ready, every out_* signal SHALL hold stable.
REQ-024 Minimum turnaround SHALL be 4 cycles per packet.
REQ-025 The beat counter SHALL never exceed 2.
REQ-026 Unused bits [28:27] SHALL be ignored.
REQ-027 All outputs SHALL be driven from registers; no combinational path SHALL exist from in_valid to out_valid.

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-EMIT, SHALL asynchronously force the following: state=IDLE, beat=0, out_valid=0, out_idx=0, out_mem=0, out_spike=0, out_src=0, out_last=0, drop_cnt=0, spike_cnt=0.
REQ-029 Any in-flight packet SHALL be lost on reset.
REQ-030 in_ready SHALL be 1 from the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 With macro SPIKE_CNT_EN defined, spike_cnt[8i+7:8i] SHALL increment by 1 on each output handshake with out_idx==i and out_spike==1, saturating at 255.
REQ-032 Without SPIKE_CNT_EN, spike_cnt SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-033 Packet {dest=100, src=000, spikes=3'b101, mem=0x30_20_10} with out_ready=1 SHALL produce beats (0,0x10,1), (1,0x20,0), (2,0x30,1,last) on cycles N+1..N+3, and in_ready SHALL return high at N+4.
REQ-034 A packet with dest=010 SHALL produce no out_valid and SHALL make drop_cnt 1; 300 such packets SHALL leave drop_cnt at 255.
REQ-035 With out_ready=0 for 5 cycles during beat 1, out_* SHALL be held at (1,0x20,0), and in_valid held high SHALL not be accepted.
REQ-036 rst_n pulsed low during beat 1 SHALL immediately zero all outputs; the next valid packet SHALL restart at beat 0.
REQ-037 With SPIKE_CNT_EN defined and 260 packets with spikes=3'b111, spike_cnt SHALL read 0xFFFFFF; without the macro it SHALL read 0.
